// File: rtl/core_dbg_pkg.sv
// rtl/core_dbg_pkg.sv - shared types for the core run/step/breakpoint controller
package core_dbg_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] addr;
        logic                    en;
    } bp_entry_t;

endpackage

// File: rtl/core_run_ctrl_if.sv
// rtl/core_run_ctrl_if.sv - board/CPU side signal bundle of the run controller
interface core_run_ctrl_if #(
    parameter int XLEN     = 64,
    parameter int BP_IDX_W = 2
);
    logic                run_mode;
    logic                step;
    logic [XLEN-1:0]     pc_in;
    logic                bp_we;
    logic [BP_IDX_W-1:0] bp_wr_idx;
    logic [XLEN-1:0]     bp_wr_addr;
    logic                bp_wr_en;
    logic                cpu_ce;
    logic                mem_ce;
    logic                halted;
    logic                bp_hit;
    logic [BP_IDX_W-1:0] bp_hit_idx;
    logic [63:0]         cycle_cnt;

    modport master (
        output run_mode, step, pc_in, bp_we, bp_wr_idx, bp_wr_addr, bp_wr_en,
        input  cpu_ce, mem_ce, halted, bp_hit, bp_hit_idx, cycle_cnt
    );

    modport slave (
        input  run_mode, step, pc_in, bp_we, bp_wr_idx, bp_wr_addr, bp_wr_en,
        output cpu_ce, mem_ce, halted, bp_hit, bp_hit_idx, cycle_cnt
    );
endinterface

// File: rtl/core_run_ctrl_step_sync.sv
// rtl/core_run_ctrl_step_sync.sv - step button synchroniser and rising-edge pulse
module step_sync (
    input  logic clk,
    input  logic aresetn,
    input  logic step_i,
    output logic step_p_o
);
    // [0] metastability catcher, [1] stable sample, [2] previous stable sample
    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], step_i};
        end
    end

    assign step_p_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - run/step/breakpoint controller issuing CPU and memory clock enables
module core_run_ctrl
    import core_dbg_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int DIV      = 2,
    parameter int NUM_BP   = 4,
    parameter int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic           clk,
    input  logic           aresetn,
    core_run_ctrl_if.slave bus
);
    localparam logic [1:0] S_HALT  = ST_HALT;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_STEP  = ST_STEP;
    localparam logic [1:0] S_BREAK = ST_BREAK;

    localparam int             CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MEM  = CNT_W'(DIV / 2 - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [63:0]         cycle_cnt_q;
    logic [BP_IDX_W-1:0] bp_hit_idx_q, bp_hit_idx_d;
    bp_entry_t           bp_q [NUM_BP];

    logic                tick;
    logic                step_p;
    logic                ce_fire;
    logic [NUM_BP-1:0]   match;
    logic                hit_any;
    logic [BP_IDX_W-1:0] hit_idx;

    assign tick = (cnt_q == CNT_LAST);

    step_sync u_step_sync (
        .clk      (clk),
        .aresetn  (aresetn),
        .step_i   (bus.step),
        .step_p_o (step_p)
    );

    for (genvar g = 0; g < NUM_BP; g++) begin : g_bp_cmp
        assign match[g] = bp_q[g].en && (bp_q[g].addr == XLEN_DEFAULT'(bus.pc_in));
    end

    // Scan from the top so the lowest matching entry wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_any = 1'b1;
                hit_idx = BP_IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bp_hit_idx_d = bp_hit_idx_q;
        ce_fire      = 1'b0;
        case (state_q)
            S_HALT: begin
                if (bus.run_mode)  state_d = S_RUN;
                else if (step_p)   state_d = S_STEP;
            end
            S_RUN: begin
                if (!bus.run_mode) begin
                    state_d = S_HALT;
                end else if (tick) begin
                    if (hit_any) begin
                        state_d      = S_BREAK;
                        bp_hit_idx_d = hit_idx;
                    end else begin
                        ce_fire = 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (tick) begin
                    ce_fire = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_BREAK: begin
                if (step_p)             state_d = S_STEP;
                else if (!bus.run_mode) state_d = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q      <= S_HALT;
            cnt_q        <= '0;
            cycle_cnt_q  <= '0;
            bp_hit_idx_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            bp_hit_idx_q <= bp_hit_idx_d;
            cnt_q        <= tick ? '0 : cnt_q + CNT_W'(1);
            if (ce_fire) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
            end
            // Writes land at this edge, so a same-cycle compare saw the old entry.
            if (bus.bp_we && (int'(bus.bp_wr_idx) < NUM_BP)) begin
                bp_q[bus.bp_wr_idx] <= '{addr: XLEN_DEFAULT'(bus.bp_wr_addr), en: bus.bp_wr_en};
            end
        end
    end

    assign bus.cpu_ce     = ce_fire & aresetn;
    assign bus.mem_ce     = (cnt_q == CNT_MEM);
    assign bus.halted     = (state_q == S_HALT) || (state_q == S_BREAK);
    assign bus.bp_hit     = (state_q == S_BREAK);
    assign bus.bp_hit_idx = bp_hit_idx_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb/tb_core_run_ctrl.sv - directed vector bench for core_run_ctrl (DIV=4, NUM_BP=4)
module tb_core_run_ctrl;

    logic clk;
    logic aresetn;

    core_run_ctrl_if #(.XLEN(64), .BP_IDX_W(2)) bus ();

    core_run_ctrl #(
        .XLEN     (64),
        .DIV      (4),
        .NUM_BP   (4),
        .BP_IDX_W (2)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          run;
        bit          step;
        logic [63:0] pc;
        bit          we;
        logic [1:0]  widx;
        logic [63:0] waddr;
        bit          wen;
        int          n;
        int          ce;
        bit          halted;
        bit          hit;
        int          idx;
        logic [63:0] cc;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_fail;
    int   model_cnt;
    int   ce_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then advance the local divider phase model.
    task automatic cyc();
        @(negedge clk);
        check("mem_ce_phase", 64'(bus.mem_ce), 64'(model_cnt == 1));
        if (model_cnt != 3) check("cpu_ce_off_tick", 64'(bus.cpu_ce), 64'd0);
        if (bus.cpu_ce === 1'b1) ce_seen++;
        @(posedge clk);
        model_cnt = aresetn ? (model_cnt + 1) % 4 : 0;
        #1;
    endtask

    task automatic add_v(input bit run, input bit step, input logic [63:0] pc,
                         input bit we, input logic [1:0] widx, input logic [63:0] waddr,
                         input bit wen, input int n, input int ce, input bit halted,
                         input bit hit, input int idx, input logic [63:0] cc);
        vec_t v;
        v = '{run, step, pc, we, widx, waddr, wen, n, ce, halted, hit, idx, cc};
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        model_cnt = 0;
        ce_seen = 0;

        //     run stp pc     we idx waddr  en  n  ce hlt hit idx  cc
        add_v(1, 0, 64'h0,   0, 0, 64'h0,   0, 40, 10, 0, 0, -1, 10);
        add_v(0, 0, 64'h0,   0, 0, 64'h0,   0,  4,  0, 1, 0, -1, 10);
        add_v(0, 1, 64'h0,   0, 0, 64'h0,   0,  4,  1, 1, 0, -1, 11);
        add_v(0, 0, 64'h0,   0, 0, 64'h0,   0, 16,  0, 1, 0, -1, 11);
        add_v(0, 1, 64'h0,   0, 0, 64'h0,   0,  4,  1, 1, 0, -1, 12);
        add_v(0, 0, 64'h0,   0, 0, 64'h0,   0, 16,  0, 1, 0, -1, 12);
        add_v(0, 1, 64'h0,   0, 0, 64'h0,   0,  4,  1, 1, 0, -1, 13);
        add_v(0, 0, 64'h0,   0, 0, 64'h0,   0, 16,  0, 1, 0, -1, 13);
        add_v(0, 1, 64'h0,   0, 0, 64'h0,   0, 50,  1, 1, 0, -1, 14);
        add_v(0, 0, 64'h0,   0, 0, 64'h0,   0,  2,  0, 1, 0, -1, 14);
        add_v(0, 0, 64'h0,   1, 2, 64'h80,  1,  1,  0, 1, 0,  0, 14);
        add_v(1, 0, 64'h70,  0, 0, 64'h0,   0,  3,  1, 0, 0, -1, 15);
        add_v(1, 0, 64'h74,  0, 0, 64'h0,   0,  4,  1, 0, 0, -1, 16);
        add_v(1, 0, 64'h78,  0, 0, 64'h0,   0,  4,  1, 0, 0, -1, 17);
        add_v(1, 0, 64'h7c,  0, 0, 64'h0,   0,  4,  1, 0, 0, -1, 18);
        add_v(1, 0, 64'h80,  0, 0, 64'h0,   0,  4,  0, 1, 1,  2, 18);
        add_v(1, 1, 64'h80,  0, 0, 64'h0,   0,  4,  1, 1, 0,  2, 19);
        add_v(1, 0, 64'h84,  0, 0, 64'h0,   0,  4,  1, 0, 0,  2, 20);
        add_v(0, 0, 64'h84,  0, 0, 64'h0,   0,  1,  0, 1, 0, -1, 20);
        add_v(0, 0, 64'h84,  1, 1, 64'h100, 1,  1,  0, 1, 0, -1, 20);
        add_v(0, 0, 64'h84,  1, 3, 64'h100, 1,  1,  0, 1, 0, -1, 20);
        add_v(1, 0, 64'h100, 0, 0, 64'h0,   0,  5,  0, 1, 1,  1, 20);
        add_v(0, 0, 64'h100, 1, 1, 64'h100, 0,  1,  0, 1, 0,  1, 20);
        add_v(1, 0, 64'h100, 0, 0, 64'h0,   0,  3,  0, 1, 1,  3, 20);
        add_v(0, 0, 64'h100, 0, 0, 64'h0,   0,  1,  0, 1, 0,  3, 20);
        add_v(1, 0, 64'h200, 0, 0, 64'h0,   0,  2,  0, 0, 0, -1, 20);
        add_v(1, 0, 64'h200, 1, 0, 64'h200, 1,  1,  1, 0, 0,  3, 21);
        add_v(1, 0, 64'h200, 0, 0, 64'h0,   0,  4,  0, 1, 1,  0, 21);
        add_v(0, 0, 64'h200, 0, 0, 64'h0,   0,  1,  0, 1, 0, -1, 21);
        add_v(1, 1, 64'h300, 0, 0, 64'h0,   0, 12,  3, 0, 0, -1, 24);
        add_v(1, 0, 64'h300, 0, 0, 64'h0,   0,  3,  1, 0, 0, -1, 25);
        add_v(1, 0, 64'h300, 0, 0, 64'h0,   0,  3,  0, 0, 0, -1, 25);
        add_v(0, 0, 64'h300, 0, 0, 64'h0,   0,  1,  0, 1, 0, -1, 25);
        add_v(0, 0, 64'h300, 0, 0, 64'h0,   0,  4,  0, 1, 0, -1, 25);

        aresetn        = 1'b0;
        bus.run_mode   = 1'b0;
        bus.step       = 1'b0;
        bus.pc_in      = '0;
        bus.bp_we      = 1'b0;
        bus.bp_wr_idx  = '0;
        bus.bp_wr_addr = '0;
        bus.bp_wr_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ce", 64'(bus.cpu_ce), 64'd0);
        check("rst_mem_ce", 64'(bus.mem_ce), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd1);
        check("rst_bp_hit", 64'(bus.bp_hit), 64'd0);
        check("rst_idx", 64'(bus.bp_hit_idx), 64'd0);
        check("rst_cycle_cnt", bus.cycle_cnt, 64'd0);
        aresetn   = 1'b1;
        model_cnt = 0;

        foreach (vecs[k]) begin
            bus.run_mode   = vecs[k].run;
            bus.step       = vecs[k].step;
            bus.pc_in      = vecs[k].pc;
            bus.bp_we      = vecs[k].we;
            bus.bp_wr_idx  = vecs[k].widx;
            bus.bp_wr_addr = vecs[k].waddr;
            bus.bp_wr_en   = vecs[k].wen;
            ce_seen = 0;
            repeat (vecs[k].n) cyc();
            check($sformatf("v%0d_ce_count", k), 64'(ce_seen), 64'(vecs[k].ce));
            check($sformatf("v%0d_halted", k), 64'(bus.halted), 64'(vecs[k].halted));
            check($sformatf("v%0d_bp_hit", k), 64'(bus.bp_hit), 64'(vecs[k].hit));
            if (vecs[k].idx >= 0)
                check($sformatf("v%0d_bp_hit_idx", k), 64'(bus.bp_hit_idx), 64'(vecs[k].idx));
            check($sformatf("v%0d_cycle_cnt", k), bus.cycle_cnt, vecs[k].cc);
        end

        // Reset lands on the STEP tick: the pending step must not fire.
        bus.bp_we    = 1'b0;
        bus.run_mode = 1'b0;
        bus.step     = 1'b1;
        ce_seen      = 0;
        repeat (3) cyc();
        check("pre_rst_step_state", 64'(bus.halted), 64'd0);
        check("pre_rst_ce", 64'(ce_seen), 64'd0);
        aresetn = 1'b0;
        @(negedge clk);
        check("rst_in_step_cpu_ce", 64'(bus.cpu_ce), 64'd0);
        @(posedge clk);
        model_cnt = 0;
        #1;
        check("rst_step_halted", 64'(bus.halted), 64'd1);
        check("rst_step_cycle_cnt", bus.cycle_cnt, 64'd0);
        check("rst_step_idx", 64'(bus.bp_hit_idx), 64'd0);
        aresetn      = 1'b1;
        bus.step     = 1'b0;
        bus.run_mode = 1'b1;
        bus.pc_in    = 64'h200;
        ce_seen      = 0;
        repeat (8) cyc();
        check("post_rst_bp_cleared_ce", 64'(ce_seen), 64'd2);
        check("post_rst_bp_hit", 64'(bus.bp_hit), 64'd0);
        check("post_rst_halted", 64'(bus.halted), 64'd0);
        check("post_rst_cycle_cnt", bus.cycle_cnt, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
